// File: rtl/io_bus_control_if.sv
// Bus/handshake bundle between cpu-side sequencing and io_bus_control.
// slave: the bus controller; master: whoever drives cycle, operands and the snooped bus.
interface io_bus_control_if;
  logic [2:0] cycle;
  logic       two_word;
  logic [3:0] data_in;
  logic [3:0] acc;
  logic [7:0] src_pair;
  logic [3:0] data_out;
  logic       data_oe;
  logic       cm_rom;
  logic [3:0] cm_ram;
  logic       io_read_valid;
  logic [3:0] io_read_data;
  logic [3:0] io_op;
  logic [7:0] src_addr;
  logic [2:0] bank;

  modport master (
    output cycle, two_word, data_in, acc, src_pair,
    input  data_out, data_oe, cm_rom, cm_ram, io_read_valid, io_read_data, io_op, src_addr, bank
  );

  modport slave (
    input  cycle, two_word, data_in, acc, src_pair,
    output data_out, data_oe, cm_rom, cm_ram, io_read_valid, io_read_data, io_op, src_addr, bank
  );
endinterface

// File: rtl/io_bus_control.sv
// X-phase bus sequencer: SRC/DCL/0xE_ I/O decode, command lines, bank and SRC address latches.
// Optional DCL_EXT_BANKS_EN enables the 3-bit (8-bank) command-line decode.
module io_bus_control #(
  parameter logic [2:0] RESET_BANK = 3'b000,
  parameter logic [7:0] SRC_RESET  = 8'h00
) (
  input logic             clk_i,
  input logic             rst_ni,
  io_bus_control_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StSrcHi, StSrcLo, StIoWr, StIoRd, StDcl} state_e;

  state_e     state_q, state_d;
  logic [3:0] op_hi_q, op_hi_d, op_lo_q, op_lo_d;
  logic       op_vld_q, op_vld_d;
  logic [2:0] bank_q, bank_d;
  logic [7:0] src_addr_q, src_addr_d;
  logic [3:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;
  logic       cm_rom_q, cm_rom_d;
  logic [3:0] cm_ram_q, cm_ram_d;
  logic       rd_vld_q, rd_vld_d;
  logic [3:0] rd_data_q, rd_data_d;
  logic [3:0] io_op_q, io_op_d;

  function automatic logic [3:0] bank_decode(input logic [2:0] b);
`ifdef DCL_EXT_BANKS_EN
    return (b == 3'b000) ? 4'b0001 : {b, 1'b0};
`else
    return 4'b0001 << b[1:0];
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    op_hi_d    = op_hi_q;
    op_lo_d    = op_lo_q;
    op_vld_d   = op_vld_q;
    bank_d     = bank_q;
    src_addr_d = src_addr_q;
    data_out_d = 4'h0;
    data_oe_d  = 1'b0;
    cm_rom_d   = 1'b0;
    cm_ram_d   = 4'h0;
    rd_vld_d   = 1'b0;
    rd_data_d  = rd_data_q;
    io_op_d    = 4'h0;

    unique case (bus.cycle)
      3'd3: begin
        cm_rom_d = 1'b1;
        op_vld_d = ~bus.two_word;
        if (!bus.two_word) begin
          op_hi_d = bus.data_in;
          if (bus.data_in == 4'hE) cm_ram_d = bank_decode(bank_q);
        end
      end
      3'd4: begin
        if (bus.two_word) op_vld_d = 1'b0;
        else              op_lo_d  = bus.data_in;
      end
      3'd5: begin
        state_d = StIdle;
        if (op_vld_q && !bus.two_word) begin
          if (op_hi_q == 4'h2 && op_lo_q[0]) begin
            state_d    = StSrcHi;
            data_out_d = bus.src_pair[7:4];
            data_oe_d  = 1'b1;
            cm_rom_d   = 1'b1;
            cm_ram_d   = bank_decode(bank_q);
            src_addr_d = bus.src_pair;
          end else if ({op_hi_q, op_lo_q} == 8'hFD) begin
            state_d = StDcl;
`ifdef DCL_EXT_BANKS_EN
            bank_d  = bus.acc[2:0];
`else
            bank_d  = {1'b0, bus.acc[1:0]};
`endif
          end else if (op_hi_q == 4'hE) begin
            io_op_d = op_lo_q;
            if (!op_lo_q[3]) begin
              state_d    = StIoWr;
              data_out_d = bus.acc;
              data_oe_d  = 1'b1;
            end else begin
              state_d = StIoRd;
            end
          end
        end
      end
      3'd6: begin
        unique case (state_q)
          StSrcHi: begin
            state_d    = StSrcLo;
            data_out_d = bus.src_pair[3:0];
            data_oe_d  = 1'b1;
          end
          StIoWr: io_op_d = op_lo_q;
          StIoRd: begin
            io_op_d   = op_lo_q;
            rd_data_d = bus.data_in;
            rd_vld_d  = 1'b1;
          end
          default: ;
        endcase
      end
      // Leaving subcycle 7 always ends the op, even if cycle wrapped early elsewhere.
      3'd7: state_d = StIdle;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      op_hi_q    <= 4'h0;
      op_lo_q    <= 4'h0;
      op_vld_q   <= 1'b0;
      bank_q     <= RESET_BANK;
      src_addr_q <= SRC_RESET;
      data_out_q <= 4'h0;
      data_oe_q  <= 1'b0;
      cm_rom_q   <= 1'b0;
      cm_ram_q   <= 4'h0;
      rd_vld_q   <= 1'b0;
      rd_data_q  <= 4'h0;
      io_op_q    <= 4'h0;
    end else begin
      state_q    <= state_d;
      op_hi_q    <= op_hi_d;
      op_lo_q    <= op_lo_d;
      op_vld_q   <= op_vld_d;
      bank_q     <= bank_d;
      src_addr_q <= src_addr_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      cm_rom_q   <= cm_rom_d;
      cm_ram_q   <= cm_ram_d;
      rd_vld_q   <= rd_vld_d;
      rd_data_q  <= rd_data_d;
      io_op_q    <= io_op_d;
    end
  end

  assign bus.data_out      = data_out_q;
  assign bus.data_oe       = data_oe_q;
  assign bus.cm_rom        = cm_rom_q;
  assign bus.cm_ram        = cm_ram_q;
  assign bus.io_read_valid = rd_vld_q;
  assign bus.io_read_data  = rd_data_q;
  assign bus.io_op         = io_op_q;
  assign bus.src_addr      = src_addr_q;
  assign bus.bank          = bank_q;

endmodule
